fp_special_classify: RTL and testbench
======================================

Name: fp_special_classify

Overview:
- Pipelined, parametrised successor to the FP adder's special-input detector.
- Classifies both operands of LANES independent add/sub lanes into six IEEE-754 classes and flags whether each lane needs the special-case bypass.
- Produces the final special-case result and per-lane invalid/sNaN exceptions, and keeps sticky exception flags.
- Sits in front of the FP adder datapath, with a valid/ready handshake so it can be stalled by the adder pipeline.

Parameters:
- WEXP, 8, exponent width.
- WSIG, 23, stored significand width, hidden bit excluded.
- LANES, 1, number of independent operand pairs processed per beat; all lanes share one handshake.
- W (localparam), 1+WEXP+WSIG, operand width: {sign, exp, sig}.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  LANES*W  operand A per lane; lane i occupies [i*W +: W].
- in_b  in  LANES*W  operand B per lane.
- in_sub  in  LANES  per-lane subtract request (effective B sign = b.sign ^ sub).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_cls_a  out  LANES*3  class of A per lane.
- out_cls_b  out  LANES*3  class of B per lane.
- out_spec  out  LANES  lane needs bypass (either operand inf or NaN).
- out_res  out  LANES*W  special-case result; valid only where out_spec=1, else all zeros.
- out_inv  out  LANES  per-lane invalid-operation exception.
- sticky_inv  out  1  sticky OR of accepted invalid exceptions.
- sticky_snan  out  1  sticky OR of accepted sNaN inputs.
- clr_sticky  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids=0; all output data registers=0; sticky flags=0. in_ready=1 from the first cycle after reset release.
- Pipeline: 2 register stages; latency exactly 2 cycles with out_ready held high; throughput 1 beat/cycle.
  - S1 registers operands, sub bits and per-operand classes.
  - S2 registers cls, spec, res and inv.
- Handshake:
  - Each stage loads when it is empty, or when its content moves on in the same cycle.
  - ready1 = ~v1 | ready2; ready2 = ~v2 | out_ready; in_ready = ready1.
  - Combinational ready path only; no skid buffer.
  - While stalled, output data must not change.
  - in_valid with in_ready=0 is not accepted; the source holds its data.
- Classification (exp=all ones = E1, sig nonzero = S):
  - ZERO: exp=0, S=0.
  - SUB: exp=0, S=1.
  - NORM: exp neither 0 nor E1.
  - INF: E1, S=0.
  - QNAN: E1, sig MSB=1.
  - SNAN: E1, S=1, sig MSB=0.
- Special result, per lane, first matching rule wins:
  1. Either operand NaN: res = canonical qNaN (sign 0, exp E1, sig = 1 followed by zeros). inv=1 if either operand is SNAN.
  2. Both INF with opposite effective signs: res = canonical qNaN, inv=1.
  3. Either operand INF: res = infinity carrying that operand's effective sign (same sign if both INF), inv=0.
  4. Otherwise: spec=0, res=0, inv=0.
- Sticky flags:
  - Updated only on an output handshake (out_valid & out_ready).
  - sticky_inv |= |out_inv; sticky_snan |= any SNAN class at the output.
  - clr_sticky together with a handshake carrying new events: the flags end the cycle holding the new events only (clear applies first, then set).
- Reset mid-operation: in-flight beats are discarded without a handshake; sticky flags are cleared.

Decomposition:
- Shared package/include (fp_pkg) holds:
  - class encodings: ZERO=0, SUB=1, NORM=2, INF=3, QNAN=4, SNAN=5;
  - a canonical-qNaN constant function of WEXP/WSIG;
  - default WEXP/WSIG.
- One sub-module, fp_lane_special: purely combinational per-lane classify and resolve, instantiated LANES times via generate.
- The top level owns pipeline registers, handshake and sticky logic.

Test Plan:
- WEXP=8, WSIG=23, LANES=1: a=0x3F800000, b=0x40000000, sub=0 -> two cycles later out_valid=1, cls_a=cls_b=NORM, spec=0, res=0, inv=0.
- a=0x7F800000, b=0x7F800000, sub=1 -> spec=1, res=0x7FC00000, inv=1; after handshake sticky_inv=1, sticky_snan=0.
- a=0x7F800001, b=0x00000001 -> cls_a=SNAN, cls_b=SUB, res=0x7FC00000, inv=1, sticky_snan=1. Then a=0xFF800000, b=0x00000000 -> res=0xFF800000, inv=0.
- out_ready=0, in_valid=1 for 4 cycles -> exactly 2 beats accepted and in_ready=0 thereafter. Raise out_ready -> beats emerge in order, unchanged, one per cycle.
- With sticky_inv=1, assert clr_sticky in the same cycle as a handshake with inv=1 -> sticky_inv stays 1. clr_sticky alone -> 0 next cycle.
- LANES=4, rst_n pulsed low while 2 beats are in flight -> out_valid=0 immediately, sticky flags 0, no stale beat after reset release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the special-input classifier.
// Holds default field widths, operand class encodings and the canonical qNaN.
package fp_pkg;

    localparam int FP_WEXP = 8;
    localparam int FP_WSIG = 23;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } fp_cls_e;

    // Canonical quiet NaN: sign 0, exponent all ones, significand 100..0.
    // Built 64 bits wide; callers keep the low 1+wexp+wsig bits.
    function automatic logic [63:0] fp_qnan(input int wexp, input int wsig);
        logic [63:0] r;
        r = ((64'd1 << wexp) - 64'd1) << wsig;
        r = r | (64'd1 << (wsig - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_lane_special.sv
// Per-lane combinational classify and special-case resolve.
// op_a_i/op_b_i -> cls_a_o/cls_b_o; S1 signs, sub and classes -> spec/res/inv.
module fp_lane_special
    import fp_pkg::*;
#(
    parameter int WEXP = FP_WEXP,
    parameter int WSIG = FP_WSIG,
    localparam int W = 1 + WEXP + WSIG
) (
    input  logic [W-1:0] op_a_i,
    input  logic [W-1:0] op_b_i,
    output logic [2:0]   cls_a_o,
    output logic [2:0]   cls_b_o,
    input  logic         sign_a_i,
    input  logic         sign_b_i,
    input  logic         sub_i,
    input  logic [2:0]   r_cls_a_i,
    input  logic [2:0]   r_cls_b_i,
    output logic         spec_o,
    output logic [W-1:0] res_o,
    output logic         inv_o
);

    localparam logic [63:0]  QNAN64 = fp_qnan(WEXP, WSIG);
    localparam logic [W-1:0] QNAN   = QNAN64[W-1:0];

    function automatic logic [2:0] classify(input logic [W-1:0] x);
        logic [WEXP-1:0] e;
        logic [WSIG-1:0] s;
        logic            e0;
        logic            e1;
        logic            s0;
        logic            msb;
        logic [2:0]      c;
        e   = x[W-2 -: WEXP];
        s   = x[WSIG-1:0];
        e0  = (e == '0);
        e1  = (e == '1);
        s0  = (s == '0);
        msb = s[WSIG-1];
        c   = CLS_ZERO;
        unique case (1'b1)
            e0 && s0:         c = CLS_ZERO;
            e0 && !s0:        c = CLS_SUB;
            !e0 && !e1:       c = CLS_NORM;
            e1 && s0:         c = CLS_INF;
            e1 && msb:        c = CLS_QNAN;
            e1 && !s0 && !msb: c = CLS_SNAN;
            default:          c = CLS_ZERO;
        endcase
        return c;
    endfunction

    assign cls_a_o = classify(op_a_i);
    assign cls_b_o = classify(op_b_i);

    logic nan_a;
    logic nan_b;
    logic snan_a;
    logic snan_b;
    logic inf_a;
    logic inf_b;
    logic esign_b;

    assign snan_a  = (r_cls_a_i == CLS_SNAN);
    assign snan_b  = (r_cls_b_i == CLS_SNAN);
    assign nan_a   = snan_a || (r_cls_a_i == CLS_QNAN);
    assign nan_b   = snan_b || (r_cls_b_i == CLS_QNAN);
    assign inf_a   = (r_cls_a_i == CLS_INF);
    assign inf_b   = (r_cls_b_i == CLS_INF);
    assign esign_b = sign_b_i ^ sub_i;

    // Rules are ordered: NaN beats inf-inf, which beats single infinity.
    always_comb begin
        spec_o = 1'b0;
        res_o  = '0;
        inv_o  = 1'b0;
        if (nan_a || nan_b) begin
            spec_o = 1'b1;
            res_o  = QNAN;
            inv_o  = snan_a || snan_b;
        end else if (inf_a && inf_b && (sign_a_i != esign_b)) begin
            spec_o = 1'b1;
            res_o  = QNAN;
            inv_o  = 1'b1;
        end else if (inf_a) begin
            spec_o = 1'b1;
            res_o  = {sign_a_i, {WEXP{1'b1}}, {WSIG{1'b0}}};
        end else if (inf_b) begin
            spec_o = 1'b1;
            res_o  = {esign_b, {WEXP{1'b1}}, {WSIG{1'b0}}};
        end
    end

endmodule

// File: rtl/fp_special_classify.sv
// Two-stage special-input classifier in front of the FP adder, LANES wide.
// in_* valid/ready beat -> out_* classes, bypass flag, result, invalid; sticky flags.
module fp_special_classify
    import fp_pkg::*;
#(
    parameter int WEXP  = FP_WEXP,
    parameter int WSIG  = FP_WSIG,
    parameter int LANES = 1,
    localparam int W = 1 + WEXP + WSIG
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    input  logic [LANES-1:0]   in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*3-1:0] out_cls_a,
    output logic [LANES*3-1:0] out_cls_b,
    output logic [LANES-1:0]   out_spec,
    output logic [LANES*W-1:0] out_res,
    output logic [LANES-1:0]   out_inv,
    output logic               sticky_inv,
    output logic               sticky_snan,
    input  logic               clr_sticky
);

    // Stage 1: only operand signs are kept; the class captures the rest.
    logic               v1_q, v1_d;
    logic [LANES-1:0]   sign_a1_q, sign_a1_d;
    logic [LANES-1:0]   sign_b1_q, sign_b1_d;
    logic [LANES-1:0]   sub1_q, sub1_d;
    logic [LANES*3-1:0] cls_a1_q, cls_a1_d;
    logic [LANES*3-1:0] cls_b1_q, cls_b1_d;

    // Stage 2
    logic               v2_q, v2_d;
    logic [LANES*3-1:0] cls_a2_q, cls_a2_d;
    logic [LANES*3-1:0] cls_b2_q, cls_b2_d;
    logic [LANES-1:0]   spec2_q, spec2_d;
    logic [LANES*W-1:0] res2_q, res2_d;
    logic [LANES-1:0]   inv2_q, inv2_d;

    logic sticky_inv_q, sticky_inv_d;
    logic sticky_snan_q, sticky_snan_d;

    logic [LANES*3-1:0] cls_a_c;
    logic [LANES*3-1:0] cls_b_c;
    logic [LANES-1:0]   spec_c;
    logic [LANES*W-1:0] res_c;
    logic [LANES-1:0]   inv_c;

    logic ready1;
    logic ready2;
    logic out_hs;
    logic snan_out;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_lane_special #(
            .WEXP (WEXP),
            .WSIG (WSIG)
        ) u_lane (
            .op_a_i    (in_a[i*W +: W]),
            .op_b_i    (in_b[i*W +: W]),
            .cls_a_o   (cls_a_c[i*3 +: 3]),
            .cls_b_o   (cls_b_c[i*3 +: 3]),
            .sign_a_i  (sign_a1_q[i]),
            .sign_b_i  (sign_b1_q[i]),
            .sub_i     (sub1_q[i]),
            .r_cls_a_i (cls_a1_q[i*3 +: 3]),
            .r_cls_b_i (cls_b1_q[i*3 +: 3]),
            .spec_o    (spec_c[i]),
            .res_o     (res_c[i*W +: W]),
            .inv_o     (inv_c[i])
        );
    end

    assign ready2   = !v2_q || out_ready;
    assign ready1   = !v1_q || ready2;
    assign in_ready = ready1;
    assign out_hs   = v2_q && out_ready;

    always_comb begin
        snan_out = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (cls_a2_q[i*3 +: 3] == CLS_SNAN) snan_out = 1'b1;
            if (cls_b2_q[i*3 +: 3] == CLS_SNAN) snan_out = 1'b1;
        end
    end

    always_comb begin
        v1_d      = ready1 ? in_valid : v1_q;
        sign_a1_d = sign_a1_q;
        sign_b1_d = sign_b1_q;
        sub1_d    = sub1_q;
        cls_a1_d  = cls_a1_q;
        cls_b1_d  = cls_b1_q;
        if (in_valid && ready1) begin
            for (int i = 0; i < LANES; i++) begin
                sign_a1_d[i] = in_a[i*W + W - 1];
                sign_b1_d[i] = in_b[i*W + W - 1];
            end
            sub1_d   = in_sub;
            cls_a1_d = cls_a_c;
            cls_b1_d = cls_b_c;
        end
    end

    always_comb begin
        v2_d     = ready2 ? v1_q : v2_q;
        cls_a2_d = cls_a2_q;
        cls_b2_d = cls_b2_q;
        spec2_d  = spec2_q;
        res2_d   = res2_q;
        inv2_d   = inv2_q;
        if (v1_q && ready2) begin
            cls_a2_d = cls_a1_q;
            cls_b2_d = cls_b1_q;
            spec2_d  = spec_c;
            res2_d   = res_c;
            inv2_d   = inv_c;
        end
    end

    // Clear first, then OR in events leaving on this cycle's handshake.
    always_comb begin
        sticky_inv_d  = clr_sticky ? 1'b0 : sticky_inv_q;
        sticky_snan_d = clr_sticky ? 1'b0 : sticky_snan_q;
        if (out_hs) begin
            sticky_inv_d  = sticky_inv_d || (|inv2_q);
            sticky_snan_d = sticky_snan_d || snan_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q          <= 1'b0;
            sign_a1_q     <= '0;
            sign_b1_q     <= '0;
            sub1_q        <= '0;
            cls_a1_q      <= '0;
            cls_b1_q      <= '0;
            v2_q          <= 1'b0;
            cls_a2_q      <= '0;
            cls_b2_q      <= '0;
            spec2_q       <= '0;
            res2_q        <= '0;
            inv2_q        <= '0;
            sticky_inv_q  <= 1'b0;
            sticky_snan_q <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            sign_a1_q     <= sign_a1_d;
            sign_b1_q     <= sign_b1_d;
            sub1_q        <= sub1_d;
            cls_a1_q      <= cls_a1_d;
            cls_b1_q      <= cls_b1_d;
            v2_q          <= v2_d;
            cls_a2_q      <= cls_a2_d;
            cls_b2_q      <= cls_b2_d;
            spec2_q       <= spec2_d;
            res2_q        <= res2_d;
            inv2_q        <= inv2_d;
            sticky_inv_q  <= sticky_inv_d;
            sticky_snan_q <= sticky_snan_d;
        end
    end

    assign out_valid   = v2_q;
    assign out_cls_a   = cls_a2_q;
    assign out_cls_b   = cls_b2_q;
    assign out_spec    = spec2_q;
    assign out_res     = res2_q;
    assign out_inv     = inv2_q;
    assign sticky_inv  = sticky_inv_q;
    assign sticky_snan = sticky_snan_q;

endmodule

// File: tb/tb_fp_special_classify.sv
// Self-checking bench for fp_special_classify (single-lane and four-lane builds).
// Vector table plus scoreboard queue; hand sequences for stall, sticky and reset.
module tb_fp_special_classify;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [2:0]  ca;
        logic [2:0]  cb;
        logic        spec;
        logic [31:0] res;
        logic        inv;
    } vec_t;

    localparam logic [2:0] ZE = 3'd0, SU = 3'd1, NO = 3'd2;
    localparam logic [2:0] IN = 3'd3, QN = 3'd4, SN = 3'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // single-lane DUT
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [0:0]  in_sub = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_cls_a;
    logic [2:0]  out_cls_b;
    logic [0:0]  out_spec;
    logic [31:0] out_res;
    logic [0:0]  out_inv;
    logic        sticky_inv;
    logic        sticky_snan;
    logic        clr_sticky = 1'b0;

    fp_special_classify #(.WEXP(8), .WSIG(23), .LANES(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sub      (in_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cls_a   (out_cls_a),
        .out_cls_b   (out_cls_b),
        .out_spec    (out_spec),
        .out_res     (out_res),
        .out_inv     (out_inv),
        .sticky_inv  (sticky_inv),
        .sticky_snan (sticky_snan),
        .clr_sticky  (clr_sticky)
    );

    // four-lane DUT
    logic         rst4_n = 1'b0;
    logic         in_valid4 = 1'b0;
    logic         in_ready4;
    logic [127:0] in_a4 = '0;
    logic [127:0] in_b4 = '0;
    logic [3:0]   in_sub4 = '0;
    logic         out_valid4;
    logic         out_ready4 = 1'b1;
    logic [11:0]  out_cls_a4;
    logic [11:0]  out_cls_b4;
    logic [3:0]   out_spec4;
    logic [127:0] out_res4;
    logic [3:0]   out_inv4;
    logic         sticky_inv4;
    logic         sticky_snan4;

    fp_special_classify #(.WEXP(8), .WSIG(23), .LANES(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst4_n),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .in_a        (in_a4),
        .in_b        (in_b4),
        .in_sub      (in_sub4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .out_cls_a   (out_cls_a4),
        .out_cls_b   (out_cls_b4),
        .out_spec    (out_spec4),
        .out_res     (out_res4),
        .out_inv     (out_inv4),
        .sticky_inv  (sticky_inv4),
        .sticky_snan (sticky_snan4),
        .clr_sticky  (1'b0)
    );

    vec_t tbl[13];
    vec_t sb[$];

    // Output monitor: every handshaken beat must match the oldest expectation.
    always @(negedge clk) begin
        vec_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", {96'd0, out_res}, 128'd0);
            end else begin
                e = sb.pop_front();
                chk("cls_a", out_cls_a, e.ca);
                chk("cls_b", out_cls_b, e.cb);
                chk("spec", out_spec, e.spec);
                chk("res", out_res, e.res);
                chk("inv", out_inv, e.inv);
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_a = v.a;
        in_b = v.b;
        in_sub = v.sub;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(v);
                done = 1;
            end else if (++n > 50) begin
                chk("send_timeout", 1, 0);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", n >= 50, 0);
    endtask

    initial begin
        int k;
        int outs;
        int n;
        logic [31:0] held;

        tbl[0]  = '{32'h3F800000, 32'h40000000, 0, NO, NO, 0, 32'h00000000, 0};
        tbl[1]  = '{32'h7F800000, 32'h7F800000, 1, IN, IN, 1, 32'h7FC00000, 1};
        tbl[2]  = '{32'h7F800001, 32'h00000001, 0, SN, SU, 1, 32'h7FC00000, 1};
        tbl[3]  = '{32'hFF800000, 32'h00000000, 0, IN, ZE, 1, 32'hFF800000, 0};
        tbl[4]  = '{32'h7FC00000, 32'h3F800000, 0, QN, NO, 1, 32'h7FC00000, 0};
        tbl[5]  = '{32'h7F800000, 32'h7F800000, 0, IN, IN, 1, 32'h7F800000, 0};
        tbl[6]  = '{32'h3F800000, 32'h7F800000, 1, NO, IN, 1, 32'hFF800000, 0};
        tbl[7]  = '{32'hFF800000, 32'h7F800000, 1, IN, IN, 1, 32'hFF800000, 0};
        tbl[8]  = '{32'h00000000, 32'h807FFFFF, 1, ZE, SU, 0, 32'h00000000, 0};
        tbl[9]  = '{32'hFFFFFFFF, 32'h7F800000, 0, QN, IN, 1, 32'h7FC00000, 0};
        tbl[10] = '{32'h7F800000, 32'hFF800000, 0, IN, IN, 1, 32'h7FC00000, 1};
        tbl[11] = '{32'h00800000, 32'h7F7FFFFF, 0, NO, NO, 0, 32'h00000000, 0};
        tbl[12] = '{32'h7FBFFFFF, 32'h7FC00001, 0, SN, QN, 1, 32'h7FC00000, 1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst4_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sticky", {sticky_inv, sticky_snan}, 0);
        chk("rst_out_res", out_res, 0);

        // first beat: exact two-cycle latency
        send(tbl[0]);
        chk("lat_cycle1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", out_valid, 1);
        drain();
        chk("sticky_after_norm", {sticky_inv, sticky_snan}, 2'b00);

        send(tbl[1]);
        drain();
        chk("sticky_after_infinf", {sticky_inv, sticky_snan}, 2'b10);

        send(tbl[2]);
        drain();
        chk("sticky_after_snan", {sticky_inv, sticky_snan}, 2'b11);

        // remaining vectors back to back
        for (int i = 3; i < 13; i++) send(tbl[i]);
        drain();

        // stall: out_ready low, source offers 4 beats
        out_ready = 1'b0;
        k = 0;
        in_valid = 1'b1;
        in_a = tbl[4].a;
        in_b = tbl[4].b;
        in_sub = tbl[4].sub;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(tbl[4 + k]);
                k++;
            end
            @(posedge clk);
            #1;
            in_a = tbl[4 + k].a;
            in_b = tbl[4 + k].b;
            in_sub = tbl[4 + k].sub;
        end
        chk("stall_accepted", k, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        held = out_res;
        @(posedge clk);
        #1;
        chk("stall_res_held", out_res, held);
        chk("stall_res_value", out_res, tbl[4].res);

        out_ready = 1'b1;
        outs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(tbl[4 + k]);
                k++;
            end
            if (out_valid) outs++;
            @(posedge clk);
            #1;
            if (k < 4) begin
                in_a = tbl[4 + k].a;
                in_b = tbl[4 + k].b;
                in_sub = tbl[4 + k].sub;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("release_accepted", k, 4);
        chk("release_out_beats", outs, 4);
        drain();

        // clear together with an invalid-carrying handshake
        chk("pre_clr_sticky", {sticky_inv, sticky_snan}, 2'b11);
        out_ready = 1'b0;
        send(tbl[1]);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clr_wait_valid", out_valid, 1);
        out_ready = 1'b1;
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("clr_with_event", {sticky_inv, sticky_snan}, 2'b10);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("clr_alone", {sticky_inv, sticky_snan}, 2'b00);
        chk("sb_empty", sb.size(), 0);

        // four lanes: one beat with lanes from table rows 0..3
        for (int i = 0; i < 4; i++) begin
            in_a4[i*32 +: 32] = tbl[i].a;
            in_b4[i*32 +: 32] = tbl[i].b;
            in_sub4[i] = tbl[i].sub;
        end
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("l4_valid", out_valid4, 1);
        for (int i = 0; i < 4; i++) begin
            chk("l4_cls_a", out_cls_a4[i*3 +: 3], tbl[i].ca);
            chk("l4_cls_b", out_cls_b4[i*3 +: 3], tbl[i].cb);
            chk("l4_spec", out_spec4[i], tbl[i].spec);
            chk("l4_res", out_res4[i*32 +: 32], tbl[i].res);
            chk("l4_inv", out_inv4[i], tbl[i].inv);
        end
        @(posedge clk);
        #1;
        chk("l4_sticky", {sticky_inv4, sticky_snan4}, 2'b11);

        // two beats in flight, then async reset mid-cycle
        in_valid4 = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst4_n = 1'b0;
        in_valid4 = 1'b0;
        #1;
        chk("l4_rst_out_valid", out_valid4, 0);
        chk("l4_rst_sticky", {sticky_inv4, sticky_snan4}, 2'b00);
        @(posedge clk);
        #1;
        rst4_n = 1'b1;
        outs = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid4) outs++;
        end
        chk("l4_no_stale_beat", outs, 0);
        chk("l4_in_ready", in_ready4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
